// File: rtl/contador_sequenciador_if.sv
// Control/readback bus between the sequencer FSM and an external loadable up/down counter.
// The sequencer drives the load/step controls; the counter returns its current value.
interface contador_sequenciador_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_up;
  logic [WIDTH-1:0] cnt_value;

  modport master (
    output cnt_load,
    output cnt_load_val,
    output cnt_en,
    output cnt_up,
    input  cnt_value
  );

  modport slave (
    input  cnt_load,
    input  cnt_load_val,
    input  cnt_en,
    input  cnt_up,
    output cnt_value
  );
endinterface

// File: rtl/contador_sequenciador.sv
// Sequencer FSM for an external up/down counter: loads it, sweeps it between limits with
// wrap or bounce at each limit, counts completed legs and pulses done/err.
module contador_sequenciador #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   hold,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       lim_lo,
  input  logic [WIDTH-1:0]       lim_hi,
  input  logic [LEG_W-1:0]       n_legs,
  contador_sequenciador_if.master ctr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [LEG_W-1:0]       leg_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRunUp,
    StRunDown,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [LEG_W-1:0]   nl_q;
  logic [LEG_W-1:0]   leg_q, leg_d, leg_next;
  logic               busy_q, done_q, err_q, err_d;
  logic               cfg_load;
  logic               last_leg, bounce, down_wrap;
  logic               load, en, up;
  logic [WIDTH-1:0]   load_val;

  assign leg_next  = leg_q + 1'b1;
  assign last_leg  = (nl_q != '0) && (leg_next == nl_q);
  assign bounce    = mode_q[1];
  assign down_wrap = (mode_q == 2'b01);

  always_comb begin
    state_d  = state_q;
    leg_d    = leg_q;
    cfg_load = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    up       = 1'b1;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          if (lim_lo >= lim_hi) begin
            err_d = 1'b1;
          end else begin
            cfg_load = 1'b1;
            leg_d    = '0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        load_val = down_wrap ? hi_q : lo_q;
        if (stop) begin
          state_d = StIdle;
        end else if (!hold) begin
          load    = 1'b1;
          state_d = down_wrap ? StRunDown : StRunUp;
        end
      end
      StRunUp: begin
        load_val = lo_q;
        if (stop) begin
          state_d = StIdle;
        end else if (!hold) begin
          if (ctr.cnt_value == hi_q) begin
            leg_d = leg_next;
            if (last_leg) begin
              state_d = StDone;
            end else if (bounce) begin
              // Reverse immediately so the limit value is shown for only one cycle.
              en      = 1'b1;
              up      = 1'b0;
              state_d = StRunDown;
            end else begin
              load = 1'b1;
            end
          end else begin
            en = 1'b1;
          end
        end
      end
      StRunDown: begin
        up       = 1'b0;
        load_val = hi_q;
        if (stop) begin
          state_d = StIdle;
        end else if (!hold) begin
          if (ctr.cnt_value == lo_q) begin
            leg_d = leg_next;
            if (last_leg) begin
              state_d = StDone;
            end else if (bounce) begin
              en      = 1'b1;
              up      = 1'b1;
              state_d = StRunUp;
            end else begin
              load = 1'b1;
            end
          end else begin
            en = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      nl_q    <= '0;
      leg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      leg_q   <= leg_d;
      err_q   <= err_d;
      busy_q  <= (state_d == StLoad) || (state_d == StRunUp) || (state_d == StRunDown);
      done_q  <= (state_d == StDone);
      if (cfg_load) begin
        mode_q <= mode;
        lo_q   <= lim_lo;
        hi_q   <= lim_hi;
        nl_q   <= n_legs;
      end
    end
  end

  assign ctr.cnt_load     = load;
  assign ctr.cnt_load_val = load_val;
  assign ctr.cnt_en       = en;
  assign ctr.cnt_up       = up;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign leg_count        = leg_q;

endmodule

// File: tb/tb_contador_sequenciador.sv
// Scoreboard bench for contador_sequenciador: a behavioural counter, a sequence-level reference
// model feeding an expectation queue, and a monitor that checks every counter update and run end.
module tb_contador_sequenciador;
  localparam int W = 4;
  localparam int L = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           hold = 1'b0;
  logic [1:0]     mode = '0;
  logic [W-1:0]   lim_lo = '0;
  logic [W-1:0]   lim_hi = '0;
  logic [L-1:0]   n_legs = '0;
  logic           busy, done, err;
  logic [L-1:0]   leg_count;
  logic [W-1:0]   cval = '0;

  contador_sequenciador_if #(.WIDTH(W)) ifc ();
  assign ifc.cnt_value = cval;

  contador_sequenciador #(.WIDTH(W), .LEG_W(L)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .mode      (mode),
    .lim_lo    (lim_lo),
    .lim_hi    (lim_hi),
    .n_legs    (n_legs),
    .ctr       (ifc.master),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .leg_count (leg_count)
  );

  always #5 clock = ~clock;

  // External counter datapath: load beats step.
  always @(posedge clock) begin
    if (ifc.cnt_load) cval <= ifc.cnt_load_val;
    else if (ifc.cnt_en) cval <= ifc.cnt_up ? cval + 1'b1 : cval - 1'b1;
  end

  typedef enum int {KCnt, KErr, KEnd} kind_e;
  typedef struct {
    kind_e kind;
    int    val;
    bit    flag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   hold_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit front_is(input kind_e k);
    return (q.size() > 0) && (q[0].kind == k);
  endfunction

  function automatic exp_t mk(input kind_e k, input int v, input bit f);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.flag = f;
    return e;
  endfunction

  // Sequence of counter values a run should produce; k>0 means stop once k updates are seen.
  task automatic build(input int md, input int lo, input int hi, input int nl, input int k,
                       output int exp_busy);
    int vals[$];
    bit ends[$];
    int v, legs, cap;
    bit up, e, bnc;
    bnc  = (md >= 2);
    up   = (md != 1);
    v    = up ? lo : hi;
    legs = 0;
    cap  = (nl == 0) ? k : 100000;
    forever begin
      e = up ? (v == hi) : (v == lo);
      vals.push_back(v);
      ends.push_back(e);
      if (vals.size() >= cap) break;
      if (e) begin
        legs++;
        if (nl != 0 && legs == nl) break;
        if (bnc) begin
          up = !up;
          v  = up ? v + 1 : v - 1;
        end else begin
          v = up ? lo : hi;
        end
      end else begin
        v = up ? (v + 1) % 16 : (v + 15) % 16;
      end
    end
    if (k > 0 && k <= vals.size()) begin
      legs = 0;
      for (int i = 0; i < k; i++) begin
        q.push_back(mk(KCnt, vals[i], 1'b0));
        if (i < k - 1 && ends[i]) legs++;
      end
      q.push_back(mk(KEnd, legs % 16, 1'b0));
      exp_busy = 1 + k;
    end else begin
      foreach (vals[i]) q.push_back(mk(KCnt, vals[i], 1'b0));
      q.push_back(mk(KEnd, nl, 1'b1));
      exp_busy = 1 + vals.size();
    end
  endtask

  // Monitor: every counter update, err pulse and end of run pops one expectation.
  bit busy_prev = 1'b0;
  always @(negedge clock) begin : monitor
    exp_t e;
    int   nxt;
    if (!reset) begin
      busy_prev = 1'b0;
    end else begin
      if (ifc.cnt_load || ifc.cnt_en) begin
        nxt = ifc.cnt_load ? int'(ifc.cnt_load_val)
                           : (ifc.cnt_up ? (int'(cval) + 1) % 16 : (int'(cval) + 15) % 16);
        if (front_is(KCnt)) begin
          e = q.pop_front();
          check("counter_value", nxt, e.val);
        end else begin
          check("unexpected_update", nxt, -1);
        end
      end
      if (err) begin
        if (front_is(KErr)) begin
          e = q.pop_front();
          check("err_busy", int'(busy), e.val);
        end else begin
          check("unexpected_err", int'(err), 0);
        end
      end
      if (busy_prev && !busy) begin
        if (front_is(KEnd)) begin
          e = q.pop_front();
          check("end_leg_count", int'(leg_count), e.val);
          check("end_done", int'(done), int'(e.flag));
        end else begin
          check("unexpected_run_end", int'(busy_prev), 0);
        end
      end else if (done) begin
        check("spurious_done", int'(done), 0);
      end
      busy_prev = busy;
    end
  end

  initial begin : hold_gen
    forever begin
      @(posedge clock);
      #1 hold = hold_en && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic chk_reset();
    check("rst_cnt_load", int'(ifc.cnt_load), 0);
    check("rst_cnt_load_val", int'(ifc.cnt_load_val), 0);
    check("rst_cnt_en", int'(ifc.cnt_en), 0);
    check("rst_cnt_up", int'(ifc.cnt_up), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_leg_count", int'(leg_count), 0);
  endtask

  task automatic run(input int md, input int lo, input int hi, input int nl, input int k,
                     input bit chk_time);
    int exp_busy, busy_cyc, n_upd, cyc;
    bit stopped;
    busy_cyc = 0;
    n_upd    = 0;
    stopped  = 1'b0;
    build(md, lo, hi, nl, k, exp_busy);
    @(negedge clock);
    start  = 1'b1;
    mode   = 2'(md);
    lim_lo = 4'(lo);
    lim_hi = 4'(hi);
    n_legs = 4'(nl);
    @(negedge clock);
    start = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) break;
      busy_cyc++;
      if (ifc.cnt_load || ifc.cnt_en) n_upd++;
      // Start and configuration must be ignored while a run is in progress.
      start  = 1'($urandom_range(0, 1));
      mode   = 2'($urandom_range(0, 3));
      lim_lo = 4'($urandom_range(0, 15));
      lim_hi = 4'($urandom_range(0, 15));
      n_legs = 4'($urandom_range(0, 15));
      if (k > 0 && n_upd == k && !stopped) begin
        stopped = 1'b1;
        @(posedge clock);
        #1 stop = 1'b1;
      end
      @(negedge clock);
    end
    start = 1'b0;
    stop  = 1'b0;
    if (cyc >= 3000) check("run_timeout", cyc, 0);
    if (chk_time) check("busy_cycles", busy_cyc, exp_busy);
    repeat (2) @(negedge clock);
  endtask

  initial begin : stim
    int lo, hi, md, nl, k, dummy;
    #1 chk_reset();
    #22 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset();

    run(2, 0, 15, 2, 0, 1'b1);
    run(0, 3, 6, 3, 0, 1'b1);
    run(1, 2, 9, 0, 19, 1'b1);

    // Configuration errors and a start masked by stop.
    q.push_back(mk(KErr, 0, 1'b0));
    @(negedge clock);
    start = 1'b1; lim_lo = 4'd8; lim_hi = 4'd8;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    q.push_back(mk(KErr, 0, 1'b0));
    start = 1'b1; lim_lo = 4'd12; lim_hi = 4'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1; stop = 1'b1; lim_lo = 4'd1; lim_hi = 4'd5;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clock);

    hold_en = 1'b1;
    run(2, 0, 15, 2, 0, 1'b0);
    run(3, 4, 11, 5, 0, 1'b0);
    hold_en = 1'b0;

    // Asynchronous reset in the middle of a down-wrap run.
    build(1, 2, 9, 0, 200, dummy);
    @(negedge clock);
    start = 1'b1; mode = 2'd1; lim_lo = 4'd2; lim_hi = 4'd9; n_legs = 4'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_reset();
    q.delete();
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    run(2, 1, 5, 2, 0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      hold_en = 1'($urandom_range(0, 1));
      md = $urandom_range(0, 3);
      lo = $urandom_range(0, 14);
      hi = $urandom_range(lo + 1, 15);
      nl = $urandom_range(0, 6);
      if (nl == 0) k = $urandom_range(1, 40);
      else k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      run(md, lo, hi, nl, k, !hold_en);
    end
    hold_en = 1'b0;
    repeat (3) @(negedge clock);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/contador_sequenciador.md
Name: contador_sequenciador

Overview:
- Control FSM that drives an external WIDTH-bit loadable up/down counter.
- Takes a run configuration: limits, mode, leg count. On start it loads the counter, steps it between limits, reverses or wraps at each limit, counts legs, and signals completion.
- Sits beside the counter datapath. It owns the counter's load, enable and direction controls and reads back the count value.

Parameters:
- WIDTH, 4: counter and limit width.
- LEG_W, 4: width of the leg count and leg counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to run; sampled only in IDLE.
- stop  in  1  abort request.
- hold  in  1  pause stepping.
- mode  in  2  run mode: 00 up-wrap, 01 down-wrap, 10 bounce, 11 treated as bounce.
- lim_lo  in  WIDTH  lower limit.
- lim_hi  in  WIDTH  upper limit.
- n_legs  in  LEG_W  legs to run; 0 = run until stop.
- cnt_value  in  WIDTH  current counter value.
- cnt_load  out  1  counter load strobe.
- cnt_load_val  out  WIDTH  value to load.
- cnt_en  out  1  counter step enable.
- cnt_up  out  1  direction: 1 = +1, 0 = -1.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle configuration-error pulse.
- leg_count  out  LEG_W  legs completed in the current or last run.

Behaviour:
- Counter contract: at a clock edge, cnt_load=1 makes the value cnt_load_val; otherwise cnt_en=1 steps it by +1 or -1 per cnt_up. Load has priority over enable.
- Reset (reset=0, asynchronous):
  - state IDLE.
  - Outputs: cnt_load=0, cnt_load_val=0, cnt_en=0, cnt_up=1, busy=0, done=0, err=0, leg_count=0.
  - Latched configuration cleared.
- States: IDLE, LOAD, RUN_UP, RUN_DOWN, DONE.
- IDLE: busy=0.
  - start=1 and stop=0:
    - If lim_lo >= lim_hi: err=1 for the next cycle, state stays IDLE.
    - Otherwise: latch mode, lim_lo, lim_hi and n_legs; clear leg_count; go to LOAD.
- LOAD (1 cycle): busy=1, cnt_load=1.
  - cnt_load_val = latched lim_hi for down-wrap, latched lim_lo otherwise.
  - Next state is RUN_DOWN for down-wrap, RUN_UP otherwise.
- RUN_UP: busy=1, cnt_up=1.
  - While cnt_value != lim_hi: cnt_en=1.
  - cnt_value == lim_hi ends a leg:
    - leg_count increments.
    - If n_legs != 0 and the new leg_count == n_legs: cnt_en=0, go to DONE.
    - Else, bounce: in the same cycle cnt_en=1, cnt_up=0, go to RUN_DOWN. Reversal has no dwell at the limit.
    - Else, up-wrap: in the same cycle cnt_load=1 with cnt_load_val=lim_lo, stay in RUN_UP. The wrap is 1 cycle, with no extra dwell.
- RUN_DOWN: mirror of RUN_UP.
  - Limit is lim_lo, step is -1.
  - Bounce reverses to RUN_UP.
  - Down-wrap reloads lim_hi.
- DONE (1 cycle): done=1, busy=0, then IDLE. start is ignored in DONE.
- cnt_load, cnt_en and cnt_up are combinational from state, latched configuration, cnt_value, hold and stop. All other outputs are registered.
- Priority is stop > hold > leg-end/step logic.
- hold=1 in LOAD/RUN_*:
  - cnt_load=0, cnt_en=0.
  - State and leg_count frozen; no leg-end evaluation.
  - Resumes in the same state when hold drops.
- stop=1 in LOAD/RUN_*/DONE: that cycle cnt_load=0 and cnt_en=0; IDLE next cycle; no done pulse. leg_count holds its value.
- start while busy is ignored. Configuration inputs are ignored except at start acceptance.
- leg_count wraps modulo 2^LEG_W when n_legs=0.
- cnt_value outside [lim_lo, lim_hi] in RUN_* (external disturbance): keep stepping in the current direction until the limit is hit. The counter wraps modulo 2^WIDTH.
- Reset asserted mid-run: immediate return to the reset values above.

Test Plan:
- Bounce, lim 0..15, n_legs=2, start at cycle 0 -> LOAD at cycle 1; cnt_value 0 at 2, 15 at 17, 14 at 18, 0 at 32; done pulse at 33; busy high cycles 1-32; leg_count=2.
- Up-wrap, lim 3..6, n_legs=3 -> sequence 3,4,5,6,3,4,5,6,3,4,5,6, no repeated values at wraps; done after the third 6.
- Down-wrap, lim 2..9, n_legs=0, stop after 20 cycles -> continuous 9..2 sweeps; stop gives cnt_en=0 that cycle and IDLE next; no done; leg_count=2.
- Config error, lim_lo=8, lim_hi=8, start -> err=1 for one cycle, busy stays 0, no cnt_load.
- Hold for 5 cycles at cnt_value=15 in bounce -> cnt_en=0, value frozen at 15, leg_count unchanged; after release, reversal to 14 occurs and leg_count increments once.
- Reset (reset=0) asserted mid-RUN_DOWN -> all outputs go to reset values asynchronously; a new start after release runs normally.
